// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
//   uart_tx_state_t - serialiser FSM states
//   UART_DATA_W     - payload bits per UART frame
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam int UART_DATA_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read data.
//   clk, rst  - clock, asynchronous active-high reset
//   wr_en     - push wr_data when not full (writes while full are ignored)
//   wr_data   - entry to push
//   rd_en     - pop the head when not empty
//   rd_data   - current head, valid while empty is low
//   full      - DEPTH entries held
//   empty     - no entries held
//   level     - current occupancy
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push, pop;

   // full/empty come straight from the registered count, so a pop in the
   // same cycle never makes room for a write.
   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr_q];

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter fed by a core store strobe.
//   clk, rst  - clock, asynchronous active-high reset
//   wr_en     - store strobe, one byte queued per cycle high
//   wr_data   - store data, only [7:0] is transmitted
//   ovf_clr   - clears the sticky overflow flag (a same-cycle drop wins)
//   txd       - registered serial output, idle high
//   full      - FIFO holds FIFO_DEPTH bytes
//   idle      - FIFO empty and serialiser idle
//   overflow  - sticky, a write was dropped because the FIFO was full
//   level     - FIFO occupancy
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_en,
   input  logic [31:0]                     wr_data,
   input  logic                            ovf_clr,
   output logic                            txd,
   output logic                            full,
   output logic                            idle,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   uart_tx_state_t         state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [UART_DATA_W-1:0] sh_q, sh_d;
   logic [UART_DATA_W-1:0] head;
   logic                   txd_q, txd_d;
   logic                   ovf_q, ovf_d;
   logic                   pop, empty, last_tick;
   logic                   unused_wr_hi;

   assign unused_wr_hi = ^wr_data[31:UART_DATA_W];

   sync_fifo #(
      .WIDTH (UART_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data[UART_DATA_W-1:0]),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign last_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = head;
               state_d = START;
            end
         end
         START: begin
            if (last_tick) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (last_tick) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (last_tick) begin
               cnt_d = '0;
               // Chain straight into the next start bit when more is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  sh_d    = head;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level follows the state one cycle later through the output flop.
   always_comb begin
      txd_d = 1'b1;
      unique case (state_q)
         START:   txd_d = 1'b0;
         DATA:    txd_d = sh_q[idx_q];
         default: txd_d = 1'b1;
      endcase
   end

   // A dropped write takes priority over a clear in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_en && full) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign txd      = txd_q;
   assign overflow = ovf_q;
   assign idle     = empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with
// CLKS_PER_BIT=4 and FIFO_DEPTH=16.
module tb_uart_tx_fifo;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 16;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        ovf_clr;
   logic        txd;
   logic        full;
   logic        idle;
   logic        overflow;
   logic [4:0]  level;

   int checks;
   int failures;

   uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .ovf_clr  (ovf_clr),
      .txd      (txd),
      .full     (full),
      .idle     (idle),
      .overflow (overflow),
      .level    (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after edge j, where txd is due to fall after edge j+1.
   // Checks all 40 line samples of the frame, ending just after edge j+40.
   task automatic frame(input logic [7:0] b, input string tag);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) begin
         tick();
         chk($sformatf("%s_bit%0d_cyc%0d", tag, i / 4, i % 4), {31'd0, txd},
             {31'd0, bits[i/4]});
         if (i == 38) chk({tag, "_idle_in_stop"}, {31'd0, idle}, 32'd0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      wr_en    = 1'b0;
      wr_data  = '0;
      ovf_clr  = 1'b0;
      tick();
      tick();
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_level", {27'd0, level}, 32'd0);
      rst = 1'b0;
      tick();
      tick();

      // Single byte 0x55, written at edge k.
      wr_en = 1'b1; wr_data = 32'h0000_0055;
      tick();
      wr_en = 1'b0;
      chk("b55_level_k", {27'd0, level}, 32'd1);
      chk("b55_idle_k", {31'd0, idle}, 32'd0);
      chk("b55_txd_k", {31'd0, txd}, 32'd1);
      tick();
      chk("b55_level_pop", {27'd0, level}, 32'd0);
      chk("b55_txd_k1", {31'd0, txd}, 32'd1);
      frame(8'h55, "b55");
      tick();
      chk("b55_idle_k42", {31'd0, idle}, 32'd1);
      chk("b55_txd_k42", {31'd0, txd}, 32'd1);
      tick();
      tick();

      // Upper store bits are discarded.
      wr_en = 1'b1; wr_data = 32'hDEAD_BE41;
      tick();
      wr_en = 1'b0;
      chk("b41_level_k", {27'd0, level}, 32'd1);
      tick();
      frame(8'h41, "b41");
      tick();
      chk("b41_idle_end", {31'd0, idle}, 32'd1);
      tick();

      // Back-to-back frames with no gap.
      wr_en = 1'b1; wr_data = 32'h0000_00A5;
      tick();
      chk("b2b_level_k", {27'd0, level}, 32'd1);
      wr_data = 32'h0000_003C;
      tick();
      wr_en = 1'b0;
      chk("b2b_level_k1", {27'd0, level}, 32'd1);
      frame(8'hA5, "b2b_a5");
      chk("b2b_level_pop2", {27'd0, level}, 32'd0);
      chk("b2b_idle_between", {31'd0, idle}, 32'd0);
      frame(8'h3C, "b2b_3c");
      tick();
      chk("b2b_idle_end", {31'd0, idle}, 32'd1);
      tick();

      // Overflow: 18 consecutive writes, the first popped at edge 2.
      for (int n = 1; n <= 18; n++) begin
         wr_en   = 1'b1;
         wr_data = 32'(n);
         tick();
         if (n == 17) begin
            chk("ovf_full_17", {31'd0, full}, 32'd1);
            chk("ovf_level_17", {27'd0, level}, 32'd16);
            chk("ovf_flag_17", {31'd0, overflow}, 32'd0);
         end
      end
      wr_en = 1'b0;
      chk("ovf_flag_18", {31'd0, overflow}, 32'd1);
      chk("ovf_level_18", {27'd0, level}, 32'd16);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", {31'd0, overflow}, 32'd0);
      wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 32'h0000_0099;
      tick();
      wr_en = 1'b0; ovf_clr = 1'b0;
      chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
      chk("ovf_level_drop", {27'd0, level}, 32'd16);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared2", {31'd0, overflow}, 32'd0);
      // Now just after edge 21; second pop lands at edge 42.
      for (int n = 22; n <= 41; n++) tick();
      chk("ovf_full_before_pop", {31'd0, full}, 32'd1);
      tick();
      chk("ovf_full_after_pop", {31'd0, full}, 32'd0);
      chk("ovf_level_after_pop", {27'd0, level}, 32'd15);

      // Reset mid-frame during data bit 3, with two bytes still queued.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      wr_en = 1'b1; wr_data = 32'h0000_0011;
      tick();
      wr_data = 32'h0000_0022;
      tick();
      wr_data = 32'h0000_0033;
      tick();
      wr_en = 1'b0;
      // Now just after edge k+2; bit 3 occupies txd after edges k+18..k+21.
      for (int n = 3; n <= 18; n++) tick();
      chk("rstmf_level_before", {27'd0, level}, 32'd2);
      chk("rstmf_txd_bit3", {31'd0, txd}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmf_txd", {31'd0, txd}, 32'd1);
      chk("rstmf_level", {27'd0, level}, 32'd0);
      chk("rstmf_idle", {31'd0, idle}, 32'd1);
      chk("rstmf_ovf", {31'd0, overflow}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      for (int n = 0; n < 50; n++) begin
         tick();
         chk($sformatf("rstmf_quiet_%0d", n), {30'd0, txd, idle}, 32'd3);
      end
      wr_en = 1'b1; wr_data = 32'h0000_000F;
      tick();
      wr_en = 1'b0;
      chk("b0f_level_k", {27'd0, level}, 32'd1);
      tick();
      frame(8'h0F, "b0f");
      tick();
      chk("b0f_idle_end", {31'd0, idle}, 32'd1);
      chk("b0f_level_end", {27'd0, level}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
